scs8hd_oai_deglitch: RTL and testbench
======================================

// Module: scs8hd_oai_deglitch
// PURPOSE
//  Parametrised, clocked successor of the o41ai cell: CH independent channels, each Y = !((|A_ch) & (&B_ch)).
//  Each raw result is registered, then passed through a per-channel stability filter, so Y only changes after
//  the new value has held for FILT consecutive enabled cycles.
//  Used on slow control/status combines (interrupt ORs, ready-AND trees) that must not propagate glitches.
// PARAMETERS
//  NA    4  OR-term inputs per channel (>=1)
//  NB    1  AND-term (B) inputs per channel (>=1)
//  CH    1  independent channels (>=1)
//  FILT  2  consecutive enabled mismatch cycles before Y updates (>=1)
// PORTS
//  CLK     in   1      clock; all state updates on rising edge
//  RESETB  in   1      reset: synchronous, active-low
//  A       in   CH*NA  OR inputs; channel c uses A[c*NA +: NA]
//  B       in   CH*NB  AND inputs; channel c uses B[c*NB +: NB]
//  EN      in   1      filter enable; 0 freezes counters and Y (sampling continues)
//  Y_RAW   out  CH     registered unfiltered OAI result
//  Y       out  CH     filtered OAI result
//  CHG     out  CH     1-cycle pulse on the cycle Y[c] takes a new value
//  BUSY    out  1      OR over channels of (counter != 0)
// BEHAVIOUR
//  Reset (RESETB=0 at an edge): Y_RAW = all 1, Y = all 1, CHG = 0, counters = 0, BUSY = 0.
//   All-ones is the OAI value for all-zero inputs. Reset overrides EN and any in-progress count.
//  Stage 1: every edge, Y_RAW[c] <= !((|A_c) & (&B_c)). Independent of EN.
//  Stage 2 (per channel, counter cnt of width $clog2(FILT+1)):
//   - EN=0: cnt, Y, hold; CHG = 0.
//   - EN=1, Y_RAW==Y: cnt <= 0; CHG <= 0.
//   - EN=1, Y_RAW!=Y, cnt < FILT-1: cnt <= cnt+1; CHG <= 0.
//   - EN=1, Y_RAW!=Y, cnt == FILT-1: Y <= Y_RAW; cnt <= 0; CHG <= 1.
//  Latency: input change -> Y_RAW at 1 edge; -> Y at FILT+1 edges (EN held 1).
//   With FILT=1, Y trails Y_RAW by exactly one cycle.
//  Glitch: mismatch shorter than FILT enabled cycles leaves Y unchanged; cnt returns to 0 on match.
//  EN toggling mid-count: count resumes from held value; mismatch need not be contiguous in wall time,
//   only contiguous over enabled cycles with no intervening match.
//  Channels are fully independent; simultaneous updates on multiple channels are allowed in the same cycle.
//  BUSY is combinational from the cnt registers; no other output is combinational from inputs.
//  No X propagation from unused states: cnt never exceeds FILT-1.
// STRUCTURE
//  Package scs8hd_oai_pkg: function oai_eval(a,b) (NA/NB generic via parameterised class or fixed-max mask),
//   localparam helper CNT_W(FILT) = $clog2(FILT+1).
//  Sub-module scs8hd_oai_filt_ch: one channel's Y_RAW compare, counter, Y and CHG registers;
//   instantiated CH times in a generate loop. Top holds the Stage-1 registers and the BUSY reduction.
// TESTING
//  T1 reset: drive RESETB=0 two edges with random A/B -> Y_RAW=Y=all 1, CHG=0, BUSY=0.
//  T2 latency, NA=4 NB=1 CH=1 FILT=2: A=4'b0010, B=1 at edge 0 -> Y_RAW=0 after edge 1, Y=0 after edge 3,
//     CHG=1 only in cycle after edge 3.
//  T3 glitch: from Y=1, set B=1, A=1 for 1 cycle then A=0 -> Y stays 1, CHG never 1, BUSY high one cycle.
//  T4 EN freeze: mismatch started, EN=0 for 5 cycles at cnt=1 -> Y, cnt hold; EN=1 -> Y updates next edge.
//  T5 multi-channel CH=3 NB=2 FILT=3: channels 0 and 2 driven to 0 together, channel 1 static -> Y=3'b010
//     after 4 edges, CHG=3'b101 single pulse.
//  T6 reset mid-count: RESETB=0 when cnt=FILT-1 -> next cycle Y=1, cnt=0, no CHG pulse.

Source files
------------

// File: rtl/scs8hd_oai_pkg.sv
// -----------------------------------------------------------------------------
// scs8hd_oai_pkg
// Shared helpers for the clocked OAI deglitch block.
//   OAI_MAX_W : widest OR/AND term group that oai_eval can evaluate
//   cnt_w()   : width of a stability counter that must hold 0..FILT-1
//   oai_eval(): !((|a[na-1:0]) & (&b[nb-1:0])) on zero-extended operands
// -----------------------------------------------------------------------------
package scs8hd_oai_pkg;

  // Callers pass zero-extended operands of this width, so NA and NB must not
  // exceed it.
  localparam int OAI_MAX_W = 64;

  // The counter only counts 0..FILT-1, but FILT+1 keeps FILT=1 at one bit.
  function automatic int cnt_w(input int filt);
    return (filt < 1) ? 1 : $clog2(filt + 1);
  endfunction

  // OR bits above na are masked to 0 and AND bits above nb are forced to 1,
  // so the zero-extension never affects the result.
  function automatic logic oai_eval(input logic [OAI_MAX_W-1:0] a,
                                    input logic [OAI_MAX_W-1:0] b,
                                    input int                   na,
                                    input int                   nb);
    logic [OAI_MAX_W-1:0] a_mask;
    logic [OAI_MAX_W-1:0] b_fill;
    a_mask = '0;
    b_fill = '0;
    for (int i = 0; i < OAI_MAX_W; i++) begin
      a_mask[i] = (i < na);
      b_fill[i] = (i >= nb);
    end
    return !((|(a & a_mask)) & (&(b | b_fill)));
  endfunction

endpackage

// File: rtl/scs8hd_oai_filt_ch.sv
// -----------------------------------------------------------------------------
// scs8hd_oai_filt_ch
// One channel's stability filter. Y follows y_raw only after y_raw has
// differed from Y for FILT consecutive enabled cycles, with no match between.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset (y=1, chg=0, counter=0)
//   en     in  filter enable; 0 freezes the counter and y
//   y_raw  in  registered unfiltered OAI value for this channel
//   y      out filtered value
//   chg    out one-cycle pulse on the cycle y takes a new value
//   busy   out counter is non-zero (a mismatch is being timed)
// -----------------------------------------------------------------------------
module scs8hd_oai_filt_ch
  import scs8hd_oai_pkg::*;
#(
  parameter int FILT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic y_raw,
  output logic y,
  output logic chg,
  output logic busy
);

  localparam int                CNT_W    = cnt_w(FILT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: reset is tested inside the clocked block, so it is synchronous and
  // takes effect only at a rising edge; it wins over en and any pending count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      y   <= 1'b1;
      chg <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (en) begin
        if (y_raw == y) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          // FILT-th consecutive enabled mismatch: accept the new value.
          y   <= y_raw;
          cnt <= '0;
          chg <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/scs8hd_oai_deglitch.sv
// -----------------------------------------------------------------------------
// scs8hd_oai_deglitch
// CH independent clocked o41ai-style channels: Y_RAW[c] = !((|A_c) & (&B_c))
// registered every edge, then filtered so Y[c] moves only after the new value
// has held for FILT consecutive enabled cycles.
// Ports:
//   CLK     in   clock
//   RESETB  in   synchronous active-low reset
//   A       in   CH*NA OR inputs, channel c uses A[c*NA +: NA]
//   B       in   CH*NB AND inputs, channel c uses B[c*NB +: NB]
//   EN      in   filter enable (Y_RAW keeps sampling when low)
//   Y_RAW   out  registered unfiltered result per channel
//   Y       out  filtered result per channel
//   CHG     out  one-cycle pulse when Y[c] changes
//   BUSY    out  any channel has a mismatch count in progress
// -----------------------------------------------------------------------------
module scs8hd_oai_deglitch
  import scs8hd_oai_pkg::*;
#(
  parameter int NA   = 4,
  parameter int NB   = 1,
  parameter int CH   = 1,
  parameter int FILT = 2
) (
  input  logic           CLK,
  input  logic           RESETB,
  input  logic [CH*NA-1:0] A,
  input  logic [CH*NB-1:0] B,
  input  logic           EN,
  output logic [CH-1:0]  Y_RAW,
  output logic [CH-1:0]  Y,
  output logic [CH-1:0]  CHG,
  output logic           BUSY
);

  logic [CH-1:0] busy_ch;

  // Stage 1: raw OAI per channel, sampled every edge regardless of EN.
  // All-ones reset is the OAI value for all-zero inputs.
  // NOTE: state registers use non-blocking assignment so every channel sees
  // the pre-edge value of its neighbours and of the filter stage.
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      Y_RAW <= '1;
    end else begin
      for (int c = 0; c < CH; c++) begin
        Y_RAW[c] <= oai_eval(OAI_MAX_W'(A[c*NA +: NA]),
                             OAI_MAX_W'(B[c*NB +: NB]), NA, NB);
      end
    end
  end

  // Stage 2: one independent filter per channel.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    scs8hd_oai_filt_ch #(
      .FILT (FILT)
    ) u_filt (
      .clk   (CLK),
      .rst_n (RESETB),
      .en    (EN),
      .y_raw (Y_RAW[c]),
      .y     (Y[c]),
      .chg   (CHG[c]),
      .busy  (busy_ch[c])
    );
  end

  assign BUSY = |busy_ch;

endmodule

// File: tb/tb_scs8hd_oai_deglitch.sv
// -----------------------------------------------------------------------------
// tb_scs8hd_oai_deglitch
// Two instances: dut_a (NA=4 NB=1 CH=1 FILT=2) and dut_b (NA=4 NB=2 CH=3
// FILT=3) share clock, reset and enable. A cycle-level reference model of the
// "value must persist for FILT enabled cycles" rule predicts every output.
// -----------------------------------------------------------------------------
module tb_scs8hd_oai_deglitch;

  logic        CLK    = 1'b0;
  logic        RESETB = 1'b0;
  logic        EN     = 1'b1;
  logic [3:0]  a_a    = '0;
  logic [0:0]  b_a    = '0;
  logic [11:0] a_b    = '0;
  logic [5:0]  b_b    = '0;

  logic [0:0]  yraw_a, y_a, chg_a;
  logic        busy_a;
  logic [2:0]  yraw_b, y_b, chg_b;
  logic        busy_b;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always #5 CLK = ~CLK;

  scs8hd_oai_deglitch #(.NA(4), .NB(1), .CH(1), .FILT(2)) dut_a (
    .CLK(CLK), .RESETB(RESETB), .A(a_a), .B(b_a), .EN(EN),
    .Y_RAW(yraw_a), .Y(y_a), .CHG(chg_a), .BUSY(busy_a)
  );

  scs8hd_oai_deglitch #(.NA(4), .NB(2), .CH(3), .FILT(3)) dut_b (
    .CLK(CLK), .RESETB(RESETB), .A(a_b), .B(b_b), .EN(EN),
    .Y_RAW(yraw_b), .Y(y_b), .CHG(chg_b), .BUSY(busy_b)
  );

  // ---------------- reference model ----------------
  // run = consecutive enabled cycles the pending raw value has differed from
  // the accepted value; reaching FILT accepts it.
  logic m_yraw [2][3];
  logic m_y    [2][3];
  logic m_chg  [2][3];
  int   m_run  [2][3];

  function automatic int ch_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int filt_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic logic raw_of(input int d, input int c);
    logic any_a;
    logic all_b;
    any_a = 1'b0;
    all_b = 1'b1;
    if (d == 0) begin
      for (int i = 0; i < 4; i++) any_a = any_a | a_a[i];
      all_b = b_a[0];
    end else begin
      for (int i = 0; i < 4; i++) any_a = any_a | a_b[c*4 + i];
      for (int i = 0; i < 2; i++) all_b = all_b & b_b[c*2 + i];
    end
    return !(any_a && all_b);
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < ch_of(d); c++) begin
        if (!RESETB) begin
          m_yraw[d][c] = 1'b1;
          m_y[d][c]    = 1'b1;
          m_chg[d][c]  = 1'b0;
          m_run[d][c]  = 0;
        end else begin
          m_chg[d][c] = 1'b0;
          if (EN) begin
            if (m_yraw[d][c] == m_y[d][c]) begin
              m_run[d][c] = 0;
            end else begin
              m_run[d][c] = m_run[d][c] + 1;
              if (m_run[d][c] == filt_of(d)) begin
                m_y[d][c]   = m_yraw[d][c];
                m_chg[d][c] = 1'b1;
                m_run[d][c] = 0;
              end
            end
          end
          m_yraw[d][c] = raw_of(d, c);
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    logic [2:0] e_yraw, e_y, e_chg;
    logic       e_busy;
    for (int d = 0; d < 2; d++) begin
      e_yraw = '0; e_y = '0; e_chg = '0; e_busy = 1'b0;
      for (int c = 0; c < ch_of(d); c++) begin
        e_yraw[c] = m_yraw[d][c];
        e_y[c]    = m_y[d][c];
        e_chg[c]  = m_chg[d][c];
        if (m_run[d][c] != 0) e_busy = 1'b1;
      end
      if (d == 0) begin
        chk("a_yraw", 32'(yraw_a), 32'(e_yraw[0]));
        chk("a_y",    32'(y_a),    32'(e_y[0]));
        chk("a_chg",  32'(chg_a),  32'(e_chg[0]));
        chk("a_busy", 32'(busy_a), 32'(e_busy));
      end else begin
        chk("b_yraw", 32'(yraw_b), 32'(e_yraw));
        chk("b_y",    32'(y_b),    32'(e_y));
        chk("b_chg",  32'(chg_b),  32'(e_chg));
        chk("b_busy", 32'(busy_b), 32'(e_busy));
      end
    end
  endtask

  // One clock: model advances on the edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 3; c++) begin
        m_yraw[d][c] = 1'b1; m_y[d][c] = 1'b1; m_chg[d][c] = 1'b0; m_run[d][c] = 0;
      end

    // T1: reset with random inputs for two edges.
    RESETB = 1'b0; EN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_a = 4'($urandom); b_a = 1'($urandom);
      a_b = 12'($urandom); b_b = 6'($urandom);
      tick();
      chk("t1_yraw", 32'({yraw_b, yraw_a}), 32'hF);
      chk("t1_y",    32'({y_b, y_a}),       32'hF);
      chk("t1_chg",  32'({chg_b, chg_a}),   32'h0);
      chk("t1_busy", 32'({busy_b, busy_a}), 32'h0);
    end
    a_a = '0; b_a = '0; a_b = '0; b_b = '0;
    RESETB = 1'b1;

    // T2: latency with FILT=2.
    a_a = 4'b0010; b_a = 1'b1;
    tick();
    chk("t2_yraw0", 32'(yraw_a), 32'h0);
    chk("t2_y_hold", 32'(y_a), 32'h1);
    tick();
    chk("t2_chg_early", 32'(chg_a), 32'h0);
    tick();
    chk("t2_y0", 32'(y_a), 32'h0);
    chk("t2_chg", 32'(chg_a), 32'h1);
    tick();
    chk("t2_chg_off", 32'(chg_a), 32'h0);

    // Return to Y=1 before the glitch test.
    a_a = 4'b0000;
    ticks(4);
    chk("t3_pre_y", 32'(y_a), 32'h1);

    // T3: one-cycle glitch.
    a_a = 4'b0001; b_a = 1'b1;
    tick();
    a_a = 4'b0000;
    tick();
    chk("t3_busy", 32'(busy_a), 32'h1);
    chk("t3_y", 32'(y_a), 32'h1);
    tick();
    chk("t3_busy_off", 32'(busy_a), 32'h0);
    ticks(2);
    chk("t3_y_final", 32'(y_a), 32'h1);

    // T4: EN freeze with the count at FILT-1.
    a_a = 4'b0001;
    ticks(2);
    EN = 1'b0;
    ticks(5);
    chk("t4_y_frozen", 32'(y_a), 32'h1);
    chk("t4_busy_frozen", 32'(busy_a), 32'h1);
    EN = 1'b1;
    tick();
    chk("t4_y_upd", 32'(y_a), 32'h0);
    chk("t4_chg", 32'(chg_a), 32'h1);

    // T6: reset while count is at FILT-1.
    a_a = 4'b0000;
    ticks(2);
    chk("t6_busy_pre", 32'(busy_a), 32'h1);
    RESETB = 1'b0;
    tick();
    chk("t6_y", 32'(y_a), 32'h1);
    chk("t6_chg", 32'(chg_a), 32'h0);
    chk("t6_busy", 32'(busy_a), 32'h0);
    RESETB = 1'b1;
    tick();

    // T5: channels 0 and 2 of dut_b go low together, channel 1 static.
    a_b = 12'h103; b_b = 6'b11_00_11;
    ticks(3);
    chk("t5_y_hold", 32'(y_b), 32'h7);
    tick();
    chk("t5_y", 32'(y_b), 32'h2);
    chk("t5_chg", 32'(chg_b), 32'h5);
    tick();
    chk("t5_chg_off", 32'(chg_b), 32'h0);

    // Random phase: inputs change occasionally so both glitches and accepted
    // changes occur; EN and reset are mostly asserted/deasserted.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) a_a = 4'($urandom);
      if ($urandom_range(3) == 0) b_a = 1'($urandom);
      if ($urandom_range(3) == 0) a_b = 12'($urandom);
      if ($urandom_range(3) == 0) b_b = 6'($urandom);
      EN     = ($urandom_range(7) != 0);
      RESETB = ($urandom_range(99) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
